// File: rtl/i2c_simple_master_if.sv
// Command/response handshake and open-drain pin signals of the byte-level I2C controller.
interface i2c_simple_master_if;
    logic       scl_di;
    logic       sda_di;
    logic       scl_pulldown;
    logic       sda_pulldown;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_start;
    logic       cmd_stop;
    logic       cmd_read;
    logic       cmd_ack;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_nack;
    logic       busy;

    modport master (
        input  scl_di, sda_di, cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_ack, cmd_data,
        output scl_pulldown, sda_pulldown, cmd_ready, rsp_valid, rsp_data, rsp_nack, busy
    );

    modport slave (
        output scl_di, sda_di, cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_ack, cmd_data,
        input  scl_pulldown, sda_pulldown, cmd_ready, rsp_valid, rsp_data, rsp_nack, busy
    );
endinterface

// File: rtl/i2c_simple_master.sv
// Byte-level I2C controller: each command is an optional (repeated) START, 8 data bits, an ACK bit
// and an optional STOP. Lines are driven open-drain through pulldown enables; SCL stretching is honoured.
module i2c_simple_master #(
    parameter int unsigned CLK_DIV = 30
) (
    input  logic                clk,
    input  logic                rst_n,
    i2c_simple_master_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACKB, S_STOP, S_HOLD} state_t;

    localparam logic [15:0] CNT_LAST = 16'(CLK_DIV - 1);

    state_t      state_q;
    logic [1:0]  qtr_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  tx_q;
    logic        read_q;
    logic        ack_q;
    logic        stop_q;
    logic [1:0]  scl_sync_q;
    logic [1:0]  sda_sync_q;
    logic        scl_pd_q;
    logic        sda_pd_q;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_data_q;
    logic        rsp_nack_q;
    logic        busy_q;

    logic        scl_hi;
    logic        sda_hi;
    logic        timed;
    logic        tick;
    logic        qtr_end;

    assign scl_hi  = scl_sync_q[1];
    assign sda_hi  = sda_sync_q[1];
    assign timed   = (state_q != S_IDLE) && (state_q != S_HOLD);
    // Q1 is the quarter that releases SCL; time stands still while a target stretches it low.
    assign tick    = timed && ((qtr_q != 2'd1) || scl_hi);
    assign qtr_end = tick && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            qtr_q       <= 2'd0;
            cnt_q       <= 16'd0;
            bit_q       <= 3'd0;
            tx_q        <= 8'h00;
            read_q      <= 1'b0;
            ack_q       <= 1'b0;
            stop_q      <= 1'b0;
            scl_sync_q  <= 2'b11;
            sda_sync_q  <= 2'b11;
            scl_pd_q    <= 1'b0;
            sda_pd_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_nack_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            scl_sync_q  <= {scl_sync_q[0], bus.scl_di};
            sda_sync_q  <= {sda_sync_q[0], bus.sda_di};
            rsp_valid_q <= 1'b0;
            if (tick) begin
                cnt_q <= qtr_end ? 16'd0 : cnt_q + 16'd1;
            end

            if (!timed) begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    tx_q        <= bus.cmd_data;
                    read_q      <= bus.cmd_read;
                    ack_q       <= bus.cmd_ack;
                    stop_q      <= bus.cmd_stop;
                    cmd_ready_q <= 1'b0;
                    qtr_q       <= 2'd0;
                    cnt_q       <= 16'd0;
                    // An unowned bus always needs a START, whatever the command asked for.
                    if (bus.cmd_start || !busy_q) begin
                        state_q  <= S_START;
                        sda_pd_q <= 1'b0;
                    end else begin
                        state_q  <= S_BIT;
                        bit_q    <= 3'd7;
                        sda_pd_q <= ~bus.cmd_read & ~bus.cmd_data[7];
                    end
                end
            end else if (qtr_end) begin
                qtr_q <= qtr_q + 2'd1;
                case (qtr_q)
                    2'd0: scl_pd_q <= 1'b0;
                    2'd1: begin
                        if (state_q == S_START) sda_pd_q <= 1'b1;
                        if (state_q == S_STOP)  sda_pd_q <= 1'b0;
                    end
                    2'd2: begin
                        if (state_q != S_STOP) scl_pd_q <= 1'b1;
                        if (state_q == S_BIT)  rsp_data_q <= {rsp_data_q[6:0], sda_hi};
                        if (state_q == S_ACKB) rsp_nack_q <= sda_hi;
                    end
                    default: begin
                        case (state_q)
                            S_START: begin
                                state_q  <= S_BIT;
                                busy_q   <= 1'b1;
                                bit_q    <= 3'd7;
                                sda_pd_q <= ~read_q & ~tx_q[7];
                            end
                            S_BIT: begin
                                if (bit_q == 3'd0) begin
                                    state_q  <= S_ACKB;
                                    sda_pd_q <= read_q & ack_q;
                                end else begin
                                    bit_q    <= bit_q - 3'd1;
                                    tx_q     <= {tx_q[6:0], 1'b0};
                                    sda_pd_q <= ~read_q & ~tx_q[6];
                                end
                            end
                            S_ACKB: begin
                                if (stop_q) begin
                                    state_q  <= S_STOP;
                                    sda_pd_q <= 1'b1;
                                end else begin
                                    state_q     <= S_HOLD;
                                    sda_pd_q    <= 1'b0;
                                    rsp_valid_q <= 1'b1;
                                    cmd_ready_q <= 1'b1;
                                end
                            end
                            S_STOP: begin
                                state_q     <= S_IDLE;
                                busy_q      <= 1'b0;
                                rsp_valid_q <= 1'b1;
                                cmd_ready_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                endcase
            end
        end
    end

    assign bus.scl_pulldown = scl_pd_q;
    assign bus.sda_pulldown = sda_pd_q;
    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_nack     = rsp_nack_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_i2c_simple_master.sv
// Directed/randomized bench for i2c_simple_master against a pulled-up bus with a behavioural target at 7'h42.
module tb_i2c_simple_master;
    localparam int         Q          = 4;
    localparam int         STRETCH    = 50;
    localparam int         LIMIT      = 2000;
    localparam logic [6:0] SLAVE_ADDR = 7'h42;
    localparam logic [7:0] SLAVE_BYTE = 8'hA5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic slave_scl = 1'b0;
    logic slave_sda = 1'b0;
    logic scl_line;
    logic sda_line;
    int   checks = 0;
    int   errors = 0;

    i2c_simple_master_if bus();

    i2c_simple_master #(.CLK_DIV(Q)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign scl_line   = !(bus.scl_pulldown || slave_scl);
    assign sda_line   = !(bus.sda_pulldown || slave_sda);
    assign bus.scl_di = scl_line;
    assign bus.sda_di = sda_line;

    // Behavioural target: address match, ACKs writes, returns SLAVE_BYTE on reads; also logs bus events.
    int         s_bit = 0;
    int         s_byte = 0;
    logic       s_sel = 1'b0;
    logic       s_rw = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic [7:0] s_sh = 8'h00;
    logic [7:0] s_tx = SLAVE_BYTE;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    logic       rise_q[$];

    always @(scl_line or sda_line) begin
        if (scl_line && prev_scl && prev_sda && !sda_line) begin
            start_cnt++;
            s_bit = -1; s_byte = 0; s_sel = 1'b0; slave_sda = 1'b0;
        end else if (scl_line && prev_scl && !prev_sda && sda_line) begin
            stop_cnt++;
            s_sel = 1'b0; slave_sda = 1'b0;
        end else if (scl_line && !prev_scl) begin
            rise_q.push_back(sda_line);
            if (s_bit >= 0 && s_bit < 8) s_sh = {s_sh[6:0], sda_line};
        end else if (!scl_line && prev_scl) begin
            s_bit++;
            if (s_bit == 8) begin
                if (s_byte == 0) begin
                    s_sel = (s_sh[7:1] == SLAVE_ADDR);
                    s_rw  = s_sh[0];
                end
                slave_sda = s_sel && (s_byte == 0 || !s_rw);
            end else begin
                if (s_bit == 9) begin
                    s_bit = 0;
                    s_byte++;
                end
                slave_sda = s_sel && s_rw && (s_byte != 0) && !s_tx[7 - s_bit];
            end
        end
        prev_scl = scl_line;
        prev_sda = sda_line;
    end

    // Transaction-level reference state.
    logic owned = 1'b0;
    logic m_sel = 1'b0;
    logic m_rw  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input string name, input logic start, input logic stop, input logic rd,
                          input logic ack, input logic [7:0] data, input int stretch_bit,
                          input int glitch_at, input int rst_at);
        int         k, base, st0, sp0, lat_exp, off, falls, stage, hold;
        logic       fresh, first, exp_ack_line, prev_pd, aborted;
        logic [7:0] exp_data, got;
        fresh = start || !owned;
        off   = (fresh && owned) ? 1 : 0;
        if (fresh) begin
            m_sel = (data[7:1] == SLAVE_ADDR);
            m_rw  = data[0];
        end
        first   = fresh;
        lat_exp = 9 * (4 * Q + 2);
        if (fresh) lat_exp += owned ? (4 * Q + 2) : (4 * Q);
        if (stop) lat_exp += 4 * Q + 2;
        if (stretch_bit >= 0) lat_exp += STRETCH;
        if (rd) begin
            exp_data     = (m_sel && m_rw && !first) ? SLAVE_BYTE : 8'hFF;
            exp_ack_line = !ack;
        end else begin
            exp_data     = data;
            exp_ack_line = !(m_sel && (first || !m_rw));
        end

        st0 = start_cnt; sp0 = stop_cnt; base = rise_q.size();
        bus.cmd_start = start; bus.cmd_stop = stop; bus.cmd_read = rd;
        bus.cmd_ack = ack; bus.cmd_data = data; bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check({name, "/ready_low"}, bus.cmd_ready, 1'b0);

        k = 0; falls = 0; stage = 0; hold = 0; aborted = 1'b0;
        prev_pd = bus.scl_pulldown;
        while (bus.rsp_valid !== 1'b1 && k < LIMIT && !aborted) begin
            @(negedge clk);
            k++;
            if (k == glitch_at) begin
                check({name, "/ready_busy"}, bus.cmd_ready, 1'b0);
                bus.cmd_valid = 1'b1;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            if (stretch_bit >= 0) begin
                if (prev_pd && !bus.scl_pulldown) begin
                    falls++;
                    if (stage == 1) begin stage = 2; hold = 0; end
                end else if (stage == 2) begin
                    hold++;
                    if (hold == STRETCH) begin slave_scl = 1'b0; stage = 3; end
                end
                if (!prev_pd && bus.scl_pulldown && stage == 0 && falls == stretch_bit) begin
                    slave_scl = 1'b1;
                    stage = 1;
                end
                prev_pd = bus.scl_pulldown;
            end
            if (k == rst_at) begin
                check({name, "/pre_scl_pd"}, bus.scl_pulldown, 1'b1);
                check({name, "/pre_sda_pd"}, bus.sda_pulldown, 1'b1);
                rst_n = 1'b0;
                #1;
                check({name, "/rst_scl_pd"}, bus.scl_pulldown, 1'b0);
                check({name, "/rst_sda_pd"}, bus.sda_pulldown, 1'b0);
                @(negedge clk);
                check({name, "/rst_ready"}, bus.cmd_ready, 1'b1);
                check({name, "/rst_busy"}, bus.busy, 1'b0);
                rst_n = 1'b1;
                aborted = 1'b1;
            end
        end
        bus.cmd_valid = 1'b0;

        if (aborted) begin
            owned = 1'b0;
            m_sel = 1'b0;
            repeat (4) @(negedge clk);
        end else begin
            check({name, "/latency"}, k, lat_exp);
            check({name, "/ready_back"}, bus.cmd_ready, 1'b1);
            check({name, "/rsp_data"}, bus.rsp_data, exp_data);
            check({name, "/rsp_nack"}, bus.rsp_nack, exp_ack_line);
            check({name, "/busy"}, bus.busy, !stop);
            check({name, "/starts"}, start_cnt - st0, fresh ? 1 : 0);
            check({name, "/stops"}, stop_cnt - sp0, stop ? 1 : 0);
            check({name, "/rises"}, rise_q.size() - base, off + 9 + (stop ? 1 : 0));
            got = 8'h00;
            for (int i = 0; i < 8; i++) begin
                if (base + off + i < rise_q.size()) got = {got[6:0], rise_q[base + off + i]};
            end
            check({name, "/bus_bits"}, got, exp_data);
            if (base + off + 8 < rise_q.size())
                check({name, "/ack_line"}, rise_q[base + off + 8], exp_ack_line);
            check({name, "/scl_pd"}, bus.scl_pulldown, !stop);
            check({name, "/sda_pd"}, bus.sda_pulldown, 1'b0);
            @(negedge clk);
            check({name, "/pulse"}, bus.rsp_valid, 1'b0);
            $display("cmd %s start=%0b stop=%0b read=%0b data=%02h -> rsp_data=%02h nack=%0b latency=%0d",
                     name, start, stop, rd, data, bus.rsp_data, bus.rsp_nack, k);
            owned = !stop;
            if (stop) m_sel = 1'b0;
        end
    endtask

    initial begin
        int n;
        bus.cmd_valid = 1'b0; bus.cmd_start = 1'b0; bus.cmd_stop = 1'b0;
        bus.cmd_read = 1'b0; bus.cmd_ack = 1'b0; bus.cmd_data = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset/scl_pd", bus.scl_pulldown, 1'b0);
        check("reset/sda_pd", bus.sda_pulldown, 1'b0);
        check("reset/ready", bus.cmd_ready, 1'b1);
        check("reset/rsp_valid", bus.rsp_valid, 1'b0);
        check("reset/rsp_data", bus.rsp_data, 8'h00);
        check("reset/rsp_nack", bus.rsp_nack, 1'b0);
        check("reset/busy", bus.busy, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        do_cmd("wr_addr", 1'b1, 1'b0, 1'b0, 1'b0, 8'h84, -1, 60, -1);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.rsp_valid) n++;
        end
        check("hold/no_rsp", n, 0);
        check("hold/scl_pd", bus.scl_pulldown, 1'b1);
        check("hold/busy", bus.busy, 1'b1);

        for (int i = 0; i < 3; i++)
            do_cmd("wr_data", 1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom), (i == 1) ? 3 : -1, -1, -1);

        do_cmd("rstart", 1'b1, 1'b0, 1'b0, 1'b0, 8'h85, -1, -1, -1);
        do_cmd("read", 1'b0, 1'b1, 1'b1, 1'b0, 8'($urandom), -1, -1, -1);
        do_cmd("noack", 1'b1, 1'b1, 1'b0, 1'b0, 8'h90, -1, -1, -1);
        do_cmd("abort", 1'b1, 1'b1, 1'b0, 1'b0, 8'h84, -1, -1, 72);
        do_cmd("after_rst", 1'b0, 1'b1, 1'b0, 1'b0, 8'h84, -1, -1, -1);
        do_cmd("rd_addr", 1'b1, 1'b0, 1'b0, 1'b0, 8'h85, -1, -1, -1);
        do_cmd("rd_ack", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, -1, -1, -1);
        do_cmd("rd_last", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
